// File: rtl/sram_line_reader.sv
// Line-read front end: fetches one SRAM line and streams words critical-word-first with wrap.
// Optional same-line bypass (no SRAM re-read) is built when LINE_READER_BYPASS_EN is defined.
module sram_line_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned WORD_WIDTH = 32,
    localparam int unsigned WORDS     = LINE_WIDTH / WORD_WIDTH,
    localparam int unsigned OW        = $clog2(WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [OW-1:0]         req_off_i,
    input  logic [OW:0]           req_len_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic                  sram_we_o,
    input  logic [LINE_WIDTH-1:0] sram_q_i,
    input  logic                  inv_i,
    output logic                  busy_o
);

    localparam logic [OW:0]   WordsLen = (OW+1)'(WORDS);
    localparam logic [OW-1:0] LastPtr  = OW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStream} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [OW-1:0]         ptr_q, ptr_d;
    logic [OW:0]           rem_q, rem_d;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  line_we;
    logic [OW:0]           eff_len;
    logic                  hit;

    // A zero or oversize length means a whole line.
    always_comb begin
        eff_len = req_len_i;
        if (req_len_i == '0 || req_len_i > WordsLen) begin
            eff_len = WordsLen;
        end
    end

`ifdef LINE_READER_BYPASS_EN
    logic [ADDR_WIDTH-1:0] tag_q;
    logic                  tag_valid_q;

    // A coincident invalidate forces the request down the full SRAM path.
    assign hit = tag_valid_q && (req_addr_i == tag_q) && !inv_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            if (line_we) begin
                tag_q       <= addr_q;
                tag_valid_q <= 1'b1;
            end
            if (inv_i) begin
                tag_valid_q <= 1'b0;
            end
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv_i;
    assign hit        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        line_we     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    ptr_d  = req_off_i;
                    rem_d  = eff_len;
                    if (hit) begin
                        state_d = StStream;
                    end else begin
                        sram_addr_d = req_addr_i;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                line_we = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                if (out_ready_i) begin
                    ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (OW+1)'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            sram_addr_q <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else if (line_we) begin
            line_q <= sram_q_i;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign out_valid_o = (state_q == StStream);
    assign out_last_o  = (state_q == StStream) && (rem_q == (OW+1)'(1));
    assign out_data_o  = line_q[ptr_q*WORD_WIDTH +: WORD_WIDTH];
    assign sram_addr_o = sram_addr_q;
    assign sram_we_o   = 1'b0;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sram_line_reader.sv
// Randomized scoreboard bench for sram_line_reader; reference model works on whole lines.
module tb_sram_line_reader;

    localparam int AW = 10;
    localparam int LW = 512;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_off = '0;
    logic [4:0]    req_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_data;
    logic          out_last;
    logic [AW-1:0] sram_addr;
    logic          sram_we;
    logic [LW-1:0] sram_q = '0;
    logic          inv = 1'b0;
    logic          busy;

    sram_line_reader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_off_i   (req_off),
        .req_len_i   (req_len),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .sram_addr_o (sram_addr),
        .sram_we_o   (sram_we),
        .sram_q_i    (sram_q),
        .inv_i       (inv),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] mem [1024];
    always @(posedge clk) sram_q <= mem[sram_addr];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Scoreboard queues and model state
    logic [WW-1:0] exp_d[$];
    logic          exp_l[$];
    int            exp_lat[$];
    logic [AW-1:0] m_tag = '0;
    bit            m_tv = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // out_ready driver: 0 always ready, 1 random, 2 fixed pattern while valid
    int   rdy_mode = 0;
    int   pidx = 0;
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: if (out_valid && pidx < 5) begin
                out_ready = pat[pidx];
                pidx++;
            end else out_ready = 1'b1;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor
    int            hs_cnt = 0;
    int            acc_cyc = 0;
    int            last_hs_cyc = 0;
    bit            lat_pend = 0;
    bit            stall_prev = 0;
    logic [WW-1:0] prev_d;
    logic          prev_l;
    always @(negedge clk) begin
        if (rst) begin
            lat_pend   = 0;
            stall_prev = 0;
        end else begin
            chk("sram_we", sram_we, 0);
            chk("ready_vs_busy", req_ready, !busy);
            if (req_valid && req_ready) begin
                acc_cyc  = cyc;
                lat_pend = 1;
            end
            if (out_valid && lat_pend) begin
                lat_pend = 0;
                if (exp_lat.size() == 0) chk("unexpected_stream", out_valid, 0);
                else chk("latency", cyc - acc_cyc, exp_lat.pop_front());
            end
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) chk("extra_word", out_valid, 0);
                else begin
                    chk("data", out_data, exp_d.pop_front());
                    chk("last", out_last, exp_l.pop_front());
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [3:0] off, input logic [4:0] len,
                          input bit wait_done);
        int            eff;
        bit            hit;
        logic [AW-1:0] sa_before;
        for (int i = 0; i < 100 && !req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_wait", req_ready, 1);
        eff = (len == 0 || len > 16) ? 16 : int'(len);
        hit = 0;
`ifdef LINE_READER_BYPASS_EN
        hit = m_tv && (m_tag == a);
`endif
        for (int i = 0; i < eff; i++) begin
            int w;
            w = (int'(off) + i) % 16;
            exp_d.push_back(mem[a][w*WW +: WW]);
            exp_l.push_back(i == eff - 1);
        end
        exp_lat.push_back(hit ? 1 : 3);
        sa_before = sram_addr;
        req_valid = 1'b1;
        req_addr  = a;
        req_off   = off;
        req_len   = len;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_off   = 4'($urandom);
        req_len   = 5'($urandom);
        chk("sram_addr", sram_addr, hit ? sa_before : a);
        if (!hit) begin
            m_tag = a;
            m_tv  = 1;
        end
        if (wait_done) begin
            for (int i = 0; i < 400 && (exp_d.size() != 0 || busy); i++) begin
                @(posedge clk);
                #1;
            end
            chk("req_done", (exp_d.size() == 0) && !busy, 1);
        end
    endtask

    task automatic pulse_inv();
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv  = 1'b0;
        m_tv = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic [AW-1:0] addrs [4] = '{10'h005, 10'h006, 10'h007, 10'h12c};
        for (int l = 0; l < 1024; l++)
            for (int k = 0; k < 16; k++) mem[l][k*WW +: WW] = $urandom;
        for (int k = 0; k < 16; k++) mem[5][k*WW +: WW] = 32'h1000 + k;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sram_addr", sram_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full line, then wrap
        do_req(10'h005, 4'd0, 5'd16, 1);
        chk("stream_span", last_hs_cyc - acc_cyc, 18);
        do_req(10'h005, 4'd14, 5'd4, 1);

        // Same line again (bypass hit when built in), then after invalidate
        do_req(10'h005, 4'd0, 5'd16, 1);
        pulse_inv();
        do_req(10'h005, 4'd3, 5'd5, 1);

        // Backpressure pattern, then zero length
        rdy_mode = 2;
        pidx     = 0;
        base     = hs_cnt;
        do_req(10'h009, 4'd6, 5'd3, 1);
        chk("bp_handshakes", hs_cnt - base, 3);
        rdy_mode = 0;
        do_req(10'h007, 4'd5, 5'd0, 1);

        // Reset mid-stream
        base = hs_cnt;
        do_req(10'h005, 4'd0, 5'd16, 0);
        for (int i = 0; i < 50 && hs_cnt < base + 2; i++) @(negedge clk);
        chk("mid_hs_seen", hs_cnt >= base + 2, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_d.delete();
        exp_l.delete();
        exp_lat.delete();
        m_tv = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) mem[5][k*WW +: WW] = $urandom;
        do_req(10'h005, 4'd2, 5'd16, 1);

        // Randomized traffic
        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) pulse_inv();
            do_req(addrs[$urandom_range(0, 3)], 4'($urandom), 5'($urandom), 1);
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        chk("queue_empty", exp_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
